// File: rtl/clock_ctrl_div.sv
// Glitch-free programmable CPU clock: run/halt/single-step, tick strobe, cycle counter.
// Optional breakpoint halt on PC match when CLOCK_CTRL_BREAK_EN is defined.
module clock_ctrl_div #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic [DIV_W-1:0] Div,
  input  logic [1:0]       Mode,
  input  logic             Step,
`ifdef CLOCK_CTRL_BREAK_EN
  input  logic [31:0]      PC,
  input  logic [31:0]      BreakPC,
  input  logic             BreakValid,
  output logic             BreakHit,
`endif
  output logic             ClockDIV,
  output logic             CpuTick,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       Estado
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b10;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_lat, div_nxt;
  logic             clk_nxt;
  logic             tick_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             step_d;
  logic             step_edge;
  logic             at_end;
  logic             do_toggle;
`ifdef CLOCK_CTRL_BREAK_EN
  logic             brk_nxt;
`endif

  assign step_edge = Step & ~step_d;
  assign at_end    = (cnt == div_lat);
  assign Estado    = state;

  // Next-state and datapath; decisions use the pre-toggle ClockDIV value
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_lat;
    clk_nxt   = ClockDIV;
    tick_nxt  = 1'b0;
    count_nxt = CycleCount;
    do_toggle = 1'b0;
`ifdef CLOCK_CTRL_BREAK_EN
    brk_nxt   = BreakHit;
`endif

    case (state)
      ST_RUN: begin
        if ((Mode != MODE_RUN) && !ClockDIV) begin
          state_nxt = ST_HALT;
          cnt_nxt   = '0;
        end else if (at_end) begin
          do_toggle = 1'b1;
          if (ClockDIV) begin
            if (Mode != MODE_RUN) state_nxt = ST_HALT;
`ifdef CLOCK_CTRL_BREAK_EN
            if (BreakValid && (PC == BreakPC)) begin
              state_nxt = ST_HALT;
              brk_nxt   = 1'b1;
            end
`endif
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end

      ST_HALT: begin
        // Keep div_lat tracking Div so the first phase after resume uses it
        clk_nxt = 1'b0;
        cnt_nxt = '0;
        div_nxt = Div;
        if (Mode == MODE_RUN) begin
          state_nxt = ST_RUN;
`ifdef CLOCK_CTRL_BREAK_EN
          brk_nxt   = 1'b0;
`endif
        end else if ((Mode == MODE_STEP) && step_edge) begin
          state_nxt = ST_STEP;
`ifdef CLOCK_CTRL_BREAK_EN
          brk_nxt   = 1'b0;
`endif
        end
      end

      ST_STEP: begin
        if (at_end) begin
          do_toggle = 1'b1;
          if (ClockDIV) state_nxt = ST_HALT;
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end

      default: begin
        state_nxt = ST_HALT;
        clk_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase

    if (do_toggle) begin
      clk_nxt = ~ClockDIV;
      cnt_nxt = '0;
      div_nxt = Div;
      if (!ClockDIV) begin
        tick_nxt  = 1'b1;
        count_nxt = CycleCount + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      state      <= ST_RUN;
      cnt        <= '0;
      div_lat    <= Div;
      ClockDIV   <= 1'b0;
      CpuTick    <= 1'b0;
      CycleCount <= '0;
      step_d     <= Step;
`ifdef CLOCK_CTRL_BREAK_EN
      BreakHit   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_lat    <= div_nxt;
      ClockDIV   <= clk_nxt;
      CpuTick    <= tick_nxt;
      CycleCount <= count_nxt;
      step_d     <= Step;
`ifdef CLOCK_CTRL_BREAK_EN
      BreakHit   <= brk_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_clock_ctrl_div.sv
// Scoreboard bench for clock_ctrl_div: directed stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_clock_ctrl_div;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 32;

  logic             CLOCK;
  logic             Reset;
  logic [DIV_W-1:0] Div;
  logic [1:0]       Mode;
  logic             Step;
  logic             ClockDIV;
  logic             CpuTick;
  logic [CNT_W-1:0] CycleCount;
  logic [1:0]       Estado;
`ifdef CLOCK_CTRL_BREAK_EN
  logic [31:0]      pc;
  logic [31:0]      break_pc;
  logic             break_valid;
  logic             break_hit;
`endif

  clock_ctrl_div #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .CLOCK      (CLOCK),
    .Reset      (Reset),
    .Div        (Div),
    .Mode       (Mode),
    .Step       (Step),
`ifdef CLOCK_CTRL_BREAK_EN
    .PC         (pc),
    .BreakPC    (break_pc),
    .BreakValid (break_valid),
    .BreakHit   (break_hit),
`endif
    .ClockDIV   (ClockDIV),
    .CpuTick    (CpuTick),
    .CycleCount (CycleCount),
    .Estado     (Estado)
  );

  typedef struct {
    int          cyc;
    logic        clk;
    logic        tick;
    logic [31:0] count;
    logic [1:0]  st;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: compares every queued expectation due at this cycle
  always @(negedge CLOCK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc < cyc)
        $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", mon_e.name, mon_e.cyc, cyc);
      else if ({ClockDIV, CpuTick, CycleCount, Estado} !== {mon_e.clk, mon_e.tick, mon_e.count, mon_e.st})
        $display("FAIL %s @%0d: got clk=%0b tick=%0b count=%0d st=%0d, want clk=%0b tick=%0b count=%0d st=%0d",
                 mon_e.name, cyc, ClockDIV, CpuTick, CycleCount, Estado,
                 mon_e.clk, mon_e.tick, mon_e.count, mon_e.st);
      else
        passed++;
    end
  end

  task automatic expect_at(input int c, input logic k, input logic t, input int unsigned n,
                           input logic [1:0] s, input string nm);
    exp_t e;
    e.cyc = c; e.clk = k; e.tick = t; e.count = n; e.st = s; e.name = nm;
    sb.push_back(e);
  endtask

  // Returns 1 time unit after posedge number n
  task automatic wait_cyc(input int n);
    do begin
      @(posedge CLOCK);
      #1;
    end while (cyc < n);
  endtask

  initial begin
    Reset = 1'b0; Div = '0; Mode = 2'b00; Step = 1'b0;
`ifdef CLOCK_CTRL_BREAK_EN
    pc = '0; break_pc = 32'h0040_0008; break_valid = 1'b0;
`endif
    // Reset then Div=0 free run: toggles every cycle
    expect_at(2,  0, 0, 0, 0, "reset_state");
    expect_at(3,  1, 1, 1, 0, "div0_rise1");
    expect_at(4,  0, 0, 1, 0, "div0_fall1");
    expect_at(5,  1, 1, 2, 0, "div0_rise2");
    expect_at(11, 1, 1, 5, 0, "div0_rise5");
    expect_at(12, 0, 0, 5, 0, "div0_fall5");
    wait_cyc(2);
    Reset = 1'b1;

    // Div=3 picked up at the next phase boundary
    wait_cyc(12);
    Div = 8'd3;
    expect_at(13, 1, 1, 6, 0, "div3_rise");
    expect_at(14, 1, 0, 6, 0, "div3_high2");
    expect_at(16, 1, 0, 6, 0, "div3_high4");
    expect_at(17, 0, 0, 6, 0, "div3_fall");
    expect_at(20, 0, 0, 6, 0, "div3_low4");
    expect_at(21, 1, 1, 7, 0, "div3_rise2");
    expect_at(24, 1, 0, 7, 0, "div3_high_end");
    expect_at(25, 0, 0, 7, 0, "div3_fall2");
    expect_at(28, 0, 0, 7, 0, "div3_low_end");
    expect_at(29, 1, 1, 8, 0, "div3_rise3");

    // Div->1 mid high phase: phase not truncated
    wait_cyc(30);
    Div = 8'd1;
    expect_at(32, 1, 0, 8, 0, "chg_high_full");
    expect_at(33, 0, 0, 8, 0, "chg_fall");
    expect_at(34, 0, 0, 8, 0, "div1_low2");
    expect_at(35, 1, 1, 9, 0, "div1_rise");
    expect_at(36, 1, 0, 9, 0, "div1_high2");
    expect_at(37, 0, 0, 9, 0, "div1_fall");
    expect_at(39, 1, 1, 10, 0, "div1_rise2");

    wait_cyc(39);
    Div = 8'd3;
    expect_at(40, 1, 0, 10, 0, "back3_high2");
    expect_at(41, 0, 0, 10, 0, "back3_fall");
    expect_at(44, 0, 0, 10, 0, "back3_low4");
    expect_at(45, 1, 1, 11, 0, "back3_rise");

    // Halt requested in 2nd high cycle: high phase completes
    wait_cyc(45);
    Mode = 2'b01;
    expect_at(46, 1, 0, 11, 0, "halt_req_high2");
    expect_at(48, 1, 0, 11, 0, "halt_req_high4");
    expect_at(49, 0, 0, 11, 1, "halt_entered");
    expect_at(55, 0, 0, 11, 1, "halt_frozen");

    // Single step with Div=1; second Step edge during STEP ignored
    wait_cyc(55);
    Mode = 2'b10; Div = 8'd1;
    expect_at(57, 0, 0, 11, 1, "step_wait");
    wait_cyc(57);
    Step = 1'b1;
    expect_at(58, 0, 0, 11, 2, "step_enter");
    expect_at(59, 0, 0, 11, 2, "step_low2");
    wait_cyc(59);
    Step = 1'b0;
    expect_at(60, 1, 1, 12, 2, "step_rise");
    wait_cyc(60);
    Step = 1'b1;
    expect_at(61, 1, 0, 12, 2, "step_high2");
    expect_at(62, 0, 0, 12, 1, "step_back_halt");
    expect_at(63, 0, 0, 12, 1, "step_no_requeue");
    expect_at(70, 0, 0, 12, 1, "step_single_edge");

    // Resume: first rise Div+1 cycles after entering RUN
    wait_cyc(70);
    Mode = 2'b00; Div = 8'd3; Step = 1'b0;
    expect_at(71, 0, 0, 12, 0, "resume_run");
    expect_at(74, 0, 0, 12, 0, "resume_low4");
    expect_at(75, 1, 1, 13, 0, "resume_rise");
    expect_at(76, 1, 0, 13, 0, "resume_high2");

    // Reset while high
    wait_cyc(76);
    Reset = 1'b0;
    expect_at(77, 0, 0, 0, 0, "reset_mid_high");
    wait_cyc(77);
    Reset = 1'b1;
    expect_at(80, 0, 0, 0, 0, "post_reset_low");
    expect_at(81, 1, 1, 1, 0, "post_reset_rise");

    // Mode=11 behaves as halt
    wait_cyc(81);
    Mode = 2'b11;
    expect_at(84, 1, 0, 1, 0, "mode3_high_full");
    expect_at(85, 0, 0, 1, 1, "mode3_halt");
    expect_at(86, 0, 0, 1, 1, "mode3_hold");

    // Halt request during low phase: immediate, no edge
    wait_cyc(86);
    Mode = 2'b00;
    expect_at(87, 0, 0, 1, 0, "run_again");
    expect_at(88, 0, 0, 1, 0, "run_low2");
    wait_cyc(88);
    Mode = 2'b01;
    expect_at(89, 0, 0, 1, 1, "halt_from_low");
    expect_at(95, 0, 0, 1, 1, "halt_low_hold");

    wait_cyc(96);
    #6;
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/clock_ctrl_div.md
Name: clock_ctrl_div

Overview:
- Programmable, glitch-free CPU clock generator driven by the board clock CLOCK.
- Replaces the fixed divide-by-2 toggle that feeds the processor's clockCPU input; memory keeps running on CLOCK.
- Adds a run-time divide ratio, halt and single-step modes, a one-cycle CPU tick strobe and a CPU cycle counter for debug on the DE board.

Parameters:
- DIV_W, 8, width of the half-period divide input.
- CNT_W, 32, width of the CPU cycle counter.

Ports:
- CLOCK  input  1  board clock; the only clock, all logic on posedge.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- Div  input  DIV_W  half-period length minus 1, in CLOCK cycles; Div=0 gives CLOCK/2.
- Mode  input  2  00 run, 01 halt, 10 step, 11 treated as halt.
- Step  input  1  step request level; its rising edge is detected internally.
- ClockDIV  output  1  registered CPU clock.
- CpuTick  output  1  high for the single CLOCK cycle in which ClockDIV rises.
- CycleCount  output  CNT_W  number of ClockDIV rising edges since reset.
- Estado  output  2  state code: 0 RUN, 1 HALT, 2 STEP.

Behaviour:
- Reset (Reset=0 at a CLOCK edge):
  - state=RUN, ClockDIV=0, CpuTick=0, CycleCount=0, cnt=0.
  - div_lat loads Div; step_d loads Step.
- Counter:
  - cnt counts 0..div_lat while counting is enabled.
  - At cnt==div_lat a toggle occurs: ClockDIV inverts, cnt returns to 0, div_lat reloads Div.
  - A Div change therefore takes effect only at a phase boundary; phases are never truncated.
- Period: each phase of ClockDIV lasts div_lat+1 CLOCK cycles; the full period is 2*(Div+1) cycles.
- Rising toggle (ClockDIV 0->1):
  - CpuTick=1 in the same register update; CpuTick=0 in every other cycle.
  - CycleCount increments by 1 and wraps modulo 2^CNT_W.
- step_edge = Step & ~step_d; step_d is updated every cycle.
- RUN:
  - Counts and toggles continuously.
  - Mode!=00 with ClockDIV=0: go to HALT next cycle and set cnt=0. No further edge occurs.
  - Mode!=00 with ClockDIV=1: finish the high phase. On the falling toggle go to HALT. No pulse is shortened.
- HALT:
  - ClockDIV is held at 0, cnt is held at 0, no toggles occur.
  - Mode==00: go to RUN. The first rise occurs Div+1 cycles after entering RUN.
  - Mode==10 and step_edge: go to STEP.
- STEP:
  - Counts a full low phase, then a rise (CpuTick=1), then a full high phase.
  - On the falling toggle, returns to HALT regardless of Mode.
  - Exactly one ClockDIV rising edge per step.
  - step_edge during STEP is ignored and not queued.
- Simultaneous events: a Mode change and a toggle in the same cycle are resolved using the pre-toggle ClockDIV value, per the rules above.
- Reset mid-phase: overrides everything. ClockDIV drops to 0 immediately on the next edge.
- Div=0: ClockDIV toggles every CLOCK cycle. The HALT/RUN/STEP rules are unchanged.

Optional Feature:
- Macro: CLOCK_CTRL_BREAK_EN.
- Defined:
  - Adds ports PC input 32, BreakPC input 32, BreakValid input 1, BreakHit output 1 (reset 0).
  - On a falling toggle in RUN with BreakValid=1 and PC==BreakPC: go to HALT and set BreakHit=1.
  - BreakHit is sticky and clears on the HALT->RUN or HALT->STEP transition.
  - After resume, the next check occurs only at the following falling edge, after PC has advanced, so there is no immediate re-trigger.
- Undefined: these four ports and all breakpoint logic are absent; behaviour is exactly as above.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1, Div=0, Mode=00 -> ClockDIV toggles every cycle; CpuTick pulses every 2 cycles; CycleCount=5 after 5 rises.
- Div=3, Mode=00 -> period of 8 CLOCK cycles, 4 high and 4 low. Change Div to 1 mid-high phase -> current high phase still lasts 4 cycles, then phases last 2 cycles.
- Div=3, Mode set to 01 on the 2nd cycle of a high phase -> high phase completes its full 4 cycles, ClockDIV then stays 0, Estado=1, CycleCount frozen.
- In HALT with Mode=10, Div=1: one Step rising edge -> exactly one rise 2 cycles later, high for 2 cycles, back to HALT, CycleCount+1. A second Step edge during STEP -> no extra rise.
- Reset=0 asserted while ClockDIV=1 in RUN -> next edge gives ClockDIV=0, CycleCount=0, Estado=0.
- With CLOCK_CTRL_BREAK_EN defined: BreakValid=1, BreakPC=0x00400008, PC reaches 0x00400008 -> HALT at the next falling edge with BreakHit=1. Then Mode=00 -> BreakHit=0, the PC advances, no re-halt.
